// File: rtl/spi_fpu_pkg.sv
// Shared definitions for the SPI command sequencer: command opcodes, arithmetic
// op encodings, sequencer states and status-byte bit positions.
package spi_fpu_pkg;

  localparam logic [3:0] OP_WRITE  = 4'd0;
  localparam logic [3:0] OP_READ   = 4'd1;
  localparam logic [3:0] OP_ADD    = 4'd2;
  localparam logic [3:0] OP_SUB    = 4'd3;
  localparam logic [3:0] OP_MUL    = 4'd4;
  localparam logic [3:0] OP_STATUS = 4'd5;

  typedef enum logic [1:0] {
    CODE_ADD = 2'd0,
    CODE_SUB = 2'd1,
    CODE_MUL = 2'd2
  } op_code_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_READ,
    S_OPERANDS,
    S_COMPUTE,
    S_STATUS,
    S_DRAIN
  } state_e;

  localparam int unsigned ST_BUSY_SEEN = 7;
  localparam int unsigned ST_ILLEGAL   = 6;
  localparam int unsigned ST_SHORT     = 5;
  localparam int unsigned ST_TIMEOUT   = 4;

  function automatic op_code_e op_code_of(input logic [3:0] opc);
    case (opc)
      OP_SUB:  return CODE_SUB;
      OP_MUL:  return CODE_MUL;
      default: return CODE_ADD;
    endcase
  endfunction

endpackage

// File: rtl/spi_fpu_regfile.sv
// NUM_REGS x WORD_BYTES register file: one full-word write port, two operand
// read ports and one snapshot read port, all reads combinational.
module spi_fpu_regfile #(
  parameter int unsigned NUM_REGS   = 4,
  parameter int unsigned WORD_BYTES = 4,
  parameter int unsigned RIDX       = $clog2(NUM_REGS)
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    we,
  input  logic [RIDX-1:0]         waddr,
  input  logic [8*WORD_BYTES-1:0] wdata,
  input  logic [RIDX-1:0]         raddr_a,
  input  logic [RIDX-1:0]         raddr_b,
  input  logic [RIDX-1:0]         raddr_s,
  output logic [8*WORD_BYTES-1:0] rdata_a,
  output logic [8*WORD_BYTES-1:0] rdata_b,
  output logic [8*WORD_BYTES-1:0] rdata_s
);

  logic [8*WORD_BYTES-1:0] regs_q [NUM_REGS];

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else if (we) begin
      regs_q[waddr] <= wdata;
    end
  end

  always_comb begin
    rdata_a = regs_q[raddr_a];
    rdata_b = regs_q[raddr_b];
    rdata_s = regs_q[raddr_s];
  end

endmodule

// File: rtl/spi_fpu_sequencer.sv
// Byte-command sequencer between the SPI byte link and an external FP unit.
// Optional build macro SPI_FPU_SEQ_FLAGS_EN accumulates op_flags into status.
module spi_fpu_sequencer
  import spi_fpu_pkg::*;
#(
  parameter int unsigned WORD_BYTES = 4,
  parameter int unsigned NUM_REGS   = 4,
  parameter int unsigned OP_TIMEOUT = 255
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    in_valid,
  input  logic [7:0]              in_data,
  input  logic                    frame_end,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [7:0]              out_data,
  output logic                    op_start,
  output logic [1:0]              op_code,
  output logic [8*WORD_BYTES-1:0] op_a,
  output logic [8*WORD_BYTES-1:0] op_b,
  input  logic                    op_done,
  input  logic [8*WORD_BYTES-1:0] op_result,
  input  logic [3:0]              op_flags,
  output logic                    busy
);

  localparam int unsigned RIDX = $clog2(NUM_REGS);
  localparam int unsigned KW   = $clog2(WORD_BYTES);
  localparam int unsigned W    = 8 * WORD_BYTES;

  state_e          state_q, state_d;
  logic [RIDX-1:0] rd_q, rd_d;
  logic [KW-1:0]   k_q, k_d;
  logic [W-1:0]    shadow_q, shadow_d;
  logic [W-1:0]    snap_q, snap_d;
  logic [W-1:0]    op_a_q, op_a_d;
  logic [W-1:0]    op_b_q, op_b_d;
  op_code_e        op_code_q, op_code_d;
  logic [15:0]     cnt_q, cnt_d;
  logic            fe_seen_q, fe_seen_d;
  logic            ill_q, ill_d, short_q, short_d, tmo_q, tmo_d, ovr_q, ovr_d;
  logic [3:0]      flags_q, flags_d;

  logic            set_ill, set_short, set_tmo, set_ovr, sticky_clr;
  logic [3:0]      set_flags;
  logic            rf_we;
  logic [W-1:0]    rf_wdata, rdata_a, rdata_b, rdata_s, wmerge;
  logic            last_byte;
  logic [7:0]      status_byte;

  function automatic logic idx_ok(input logic [3:0] idx);
    return 32'(idx) < NUM_REGS;
  endfunction

  spi_fpu_regfile #(
    .NUM_REGS   (NUM_REGS),
    .WORD_BYTES (WORD_BYTES),
    .RIDX       (RIDX)
  ) u_regfile (
    .clock   (clock),
    .reset   (reset),
    .we      (rf_we),
    .waddr   (rd_q),
    .wdata   (rf_wdata),
    .raddr_a (in_data[4 +: RIDX]),
    .raddr_b (in_data[0 +: RIDX]),
    .raddr_s (in_data[0 +: RIDX]),
    .rdata_a (rdata_a),
    .rdata_b (rdata_b),
    .rdata_s (rdata_s)
  );

  always_comb begin
    wmerge = shadow_q;
    wmerge[8*k_q +: 8] = in_data;
    last_byte = (k_q == KW'(WORD_BYTES - 1));
  end

  always_ff @(posedge clock) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    rd_d       = rd_q;
    k_d        = k_q;
    shadow_d   = shadow_q;
    snap_d     = snap_q;
    op_a_d     = op_a_q;
    op_b_d     = op_b_q;
    op_code_d  = op_code_q;
    cnt_d      = cnt_q;
    fe_seen_d  = fe_seen_q;
    set_ill    = 1'b0;
    set_short  = 1'b0;
    set_tmo    = 1'b0;
    set_ovr    = 1'b0;
    set_flags  = '0;
    sticky_clr = 1'b0;
    rf_we      = 1'b0;
    rf_wdata   = '0;

    case (state_q)
      S_IDLE: begin
        if (!frame_end && in_valid) begin
          rd_d     = in_data[0 +: RIDX];
          k_d      = '0;
          shadow_d = '0;
          if (!idx_ok(in_data[3:0])) begin
            set_ill = 1'b1;
            state_d = S_DRAIN;
          end else begin
            case (in_data[7:4])
              OP_WRITE: state_d = S_WRITE;
              OP_READ: begin
                snap_d  = rdata_s;
                state_d = S_READ;
              end
              OP_ADD, OP_SUB, OP_MUL: begin
                op_code_d = op_code_of(in_data[7:4]);
                state_d   = S_OPERANDS;
              end
              OP_STATUS: state_d = S_STATUS;
              default: begin
                set_ill = 1'b1;
                state_d = S_DRAIN;
              end
            endcase
          end
        end
      end

      S_WRITE: begin
        if (in_valid && last_byte) begin
          rf_we    = 1'b1;
          rf_wdata = wmerge;
          state_d  = frame_end ? S_IDLE : S_DRAIN;
        end else if (frame_end) begin
          set_short = 1'b1;
          shadow_d  = '0;
          state_d   = S_IDLE;
        end else if (in_valid) begin
          shadow_d = wmerge;
          k_d      = k_q + 1'b1;
        end
      end

      S_READ: begin
        if (frame_end) begin
          state_d = S_IDLE;
        end else if (out_ready) begin
          if (last_byte) state_d = S_DRAIN;
          else           k_d     = k_q + 1'b1;
        end
      end

      S_OPERANDS: begin
        if (frame_end) begin
          state_d = S_IDLE;
        end else if (in_valid) begin
          if (!(idx_ok(in_data[7:4]) && idx_ok(in_data[3:0]))) begin
            set_ill = 1'b1;
            state_d = S_DRAIN;
          end else begin
            op_a_d    = rdata_a;
            op_b_d    = rdata_b;
            cnt_d     = '0;
            fe_seen_d = 1'b0;
            state_d   = S_COMPUTE;
          end
        end
      end

      // cnt_q == 0 marks the issue cycle; done is accepted up to OP_TIMEOUT cycles later
      S_COMPUTE: begin
        if (in_valid) set_ovr = 1'b1;
        if (op_done) begin
          rf_we    = 1'b1;
          rf_wdata = op_result;
`ifdef SPI_FPU_SEQ_FLAGS_EN
          set_flags = op_flags;
`endif
          state_d  = (fe_seen_q || frame_end) ? S_IDLE : S_DRAIN;
        end else if (cnt_q == 16'(OP_TIMEOUT)) begin
          set_tmo = 1'b1;
          state_d = (fe_seen_q || frame_end) ? S_IDLE : S_DRAIN;
        end else begin
          cnt_d = cnt_q + 16'd1;
          if (frame_end) fe_seen_d = 1'b1;
        end
      end

      S_STATUS: begin
        if (out_ready) begin
          sticky_clr = 1'b1;
          state_d    = frame_end ? S_IDLE : S_DRAIN;
        end else if (frame_end) begin
          state_d = S_IDLE;
        end
      end

      S_DRAIN: begin
        if (frame_end) state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase

    ill_d   = (sticky_clr ? 1'b0 : ill_q)   | set_ill;
    short_d = (sticky_clr ? 1'b0 : short_q) | set_short;
    tmo_d   = (sticky_clr ? 1'b0 : tmo_q)   | set_tmo;
    ovr_d   = (sticky_clr ? 1'b0 : ovr_q)   | set_ovr;
    flags_d = (sticky_clr ? 4'd0 : flags_q) | set_flags;
  end

`ifndef SPI_FPU_SEQ_FLAGS_EN
  logic unused_op_flags;
  always_comb unused_op_flags = ^op_flags;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      rd_q      <= '0;
      k_q       <= '0;
      shadow_q  <= '0;
      snap_q    <= '0;
      op_a_q    <= '0;
      op_b_q    <= '0;
      op_code_q <= CODE_ADD;
      cnt_q     <= '0;
      fe_seen_q <= 1'b0;
      ill_q     <= 1'b0;
      short_q   <= 1'b0;
      tmo_q     <= 1'b0;
      ovr_q     <= 1'b0;
      flags_q   <= '0;
    end else begin
      rd_q      <= rd_d;
      k_q       <= k_d;
      shadow_q  <= shadow_d;
      snap_q    <= snap_d;
      op_a_q    <= op_a_d;
      op_b_q    <= op_b_d;
      op_code_q <= op_code_d;
      cnt_q     <= cnt_d;
      fe_seen_q <= fe_seen_d;
      ill_q     <= ill_d;
      short_q   <= short_d;
      tmo_q     <= tmo_d;
      ovr_q     <= ovr_d;
      flags_q   <= flags_d;
    end
  end

  always_comb begin
    status_byte               = '0;
    status_byte[ST_BUSY_SEEN] = 1'b0;
    status_byte[ST_ILLEGAL]   = ill_q;
    status_byte[ST_SHORT]     = short_q;
    status_byte[ST_TIMEOUT]   = tmo_q;
    status_byte[3:0]          = flags_q;

    busy      = (state_q != S_IDLE);
    out_valid = (state_q == S_READ) || (state_q == S_STATUS);
    out_data  = '0;
    if (state_q == S_READ)   out_data = snap_q[8*k_q +: 8];
    if (state_q == S_STATUS) out_data = status_byte;
    op_start  = (state_q == S_COMPUTE) && (cnt_q == 16'd0);
    op_a      = op_a_q;
    op_b      = op_b_q;
    op_code   = op_code_q;
  end

endmodule

// File: tb/tb_spi_fpu_sequencer.sv
// Directed bench for spi_fpu_sequencer: table-driven register round trips plus
// hand-written arithmetic, timeout, short-write, illegal and reset sequences.
module tb_spi_fpu_sequencer;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid, frame_end, out_ready;
  logic [7:0]  in_data;
  logic        out_valid, op_start, busy;
  logic [7:0]  out_data;
  logic [1:0]  op_code;
  logic [31:0] op_a, op_b;
  logic        op_done;
  logic [31:0] op_result;
  logic [3:0]  op_flags;

  int pass_cnt = 0;
  int total_cnt = 0;

  int          starts = 0;
  int          cd = 0;
  bit          model_en = 1'b0;
  bit          man_done = 1'b0;
  logic [31:0] cap_a, cap_b;
  logic [1:0]  cap_code;

  always #5 clock = ~clock;

  spi_fpu_sequencer #(
    .WORD_BYTES (4),
    .NUM_REGS   (4),
    .OP_TIMEOUT (8)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .frame_end (frame_end),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .op_start  (op_start),
    .op_code   (op_code),
    .op_a      (op_a),
    .op_b      (op_b),
    .op_done   (op_done),
    .op_result (op_result),
    .op_flags  (op_flags),
    .busy      (busy)
  );

  // FP unit model: answers 5 cycles after op_start when enabled
  always @(posedge clock) begin
    if (op_start) begin
      starts   <= starts + 1;
      cap_a    <= op_a;
      cap_b    <= op_b;
      cap_code <= op_code;
      if (model_en) cd <= 5;
    end else if (cd > 0) begin
      cd <= cd - 1;
    end
  end
  assign op_done   = (cd == 1) || man_done;
  assign op_result = 32'h4040_0000;
  assign op_flags  = 4'h9;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  task automatic send(input logic [7:0] b);
    in_valid = 1'b1;
    in_data  = b;
    @(negedge clock);
    in_valid = 1'b0;
  endtask

  task automatic fend();
    frame_end = 1'b1;
    @(negedge clock);
    frame_end = 1'b0;
  endtask

  task automatic wait_out(input string nm);
    int g = 0;
    while (!out_valid && g < 16) begin
      @(negedge clock);
      g++;
    end
    if (g == 16) check(nm, out_valid, 1'b1);
  endtask

  task automatic write_word(input logic [3:0] idx, input logic [31:0] w);
    send({4'h0, idx});
    for (int k = 0; k < 4; k++) send(w[8*k +: 8]);
    fend();
  endtask

  task automatic read_word(input logic [3:0] idx, output logic [31:0] w);
    w = '0;
    send({4'h1, idx});
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wait_out("read_wait");
      w[8*k +: 8] = out_data;
      @(negedge clock);
    end
    out_ready = 1'b0;
    fend();
  endtask

  task automatic status_read(output logic [7:0] s);
    send(8'h50);
    wait_out("status_wait");
    s = out_data;
    out_ready = 1'b1;
    @(negedge clock);
    out_ready = 1'b0;
    fend();
  endtask

  typedef struct packed {
    logic [3:0]      idx;
    logic [31:0]     wdata;
    logic [0:3][7:0] exp;
  } rt_vec_t;

  rt_vec_t     vecs [4];
  logic [31:0] w;
  logic [7:0]  s;
  logic [7:0]  exp_flags;
  bit          stall_rdy [7];
  logic [7:0]  stall_exp [7];

  initial begin
    vecs[0] = '{4'd0, 32'h1234_5678, {8'h78, 8'h56, 8'h34, 8'h12}};
    vecs[1] = '{4'd1, 32'hCAFE_F00D, {8'h0D, 8'hF0, 8'hFE, 8'hCA}};
    vecs[2] = '{4'd3, 32'hA5C3_0F81, {8'h81, 8'h0F, 8'hC3, 8'hA5}};
    vecs[3] = '{4'd2, 32'h00FF_00FF, {8'hFF, 8'h00, 8'hFF, 8'h00}};
    stall_rdy = '{1, 1, 0, 0, 0, 1, 1};
    stall_exp = '{8'h78, 8'h56, 8'h34, 8'h34, 8'h34, 8'h34, 8'h12};
`ifdef SPI_FPU_SEQ_FLAGS_EN
    exp_flags = 8'h09;
`else
    exp_flags = 8'h00;
`endif

    reset = 1'b1; in_valid = 1'b0; in_data = '0; frame_end = 1'b0; out_ready = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check("rst_busy", busy, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_op_start", op_start, 0);
    check("rst_op_a", op_a, 0);
    check("rst_op_b", op_b, 0);
    check("rst_op_code", op_code, 0);

    // register round trips
    for (int i = 0; i < 4; i++) begin
      write_word(vecs[i].idx, vecs[i].wdata);
      read_word(vecs[i].idx, w);
      for (int k = 0; k < 4; k++)
        check($sformatf("rt%0d_byte%0d", i, k), w[8*k +: 8], vecs[i].exp[k]);
    end
    status_read(s);
    check("status_clean", s, 8'h00);

    // read r0 with out_ready held low at byte 2
    send(8'h10);
    for (int n = 0; n < 7; n++) begin
      check($sformatf("stall_valid%0d", n), out_valid, 1);
      check($sformatf("stall_data%0d", n), out_data, stall_exp[n]);
      out_ready = stall_rdy[n];
      @(negedge clock);
    end
    out_ready = 1'b0;
    check("stall_done_valid", out_valid, 0);
    fend();

    // ADD r2 = r0 + r1
    write_word(4'd0, 32'h3F80_0000);
    write_word(4'd1, 32'h4000_0000);
    model_en = 1'b1;
    starts = 0;
    send(8'h22);
    send(8'h01);
    check("add_op_start", op_start, 1);
    check("add_op_a_at_start", op_a, 32'h3F80_0000);
    repeat (10) @(negedge clock);
    fend();
    check("add_busy_after", busy, 0);
    check("add_start_count", starts, 1);
    check("add_cap_a", cap_a, 32'h3F80_0000);
    check("add_cap_b", cap_b, 32'h4000_0000);
    check("add_cap_code", cap_code, 2'd0);
    read_word(4'd2, w);
    check("add_r2", w, 32'h4040_0000);
    status_read(s);
    check("add_status_flags", s, exp_flags);

    // timeout: model silent, late done ignored
    model_en = 1'b0;
    starts = 0;
    send(8'h22);
    send(8'h01);
    repeat (14) @(negedge clock);
    check("tmo_start_count", starts, 1);
    man_done = 1'b1;
    @(negedge clock);
    man_done = 1'b0;
    fend();
    check("tmo_busy_after", busy, 0);
    read_word(4'd2, w);
    check("tmo_r2_unchanged", w, 32'h4040_0000);
    status_read(s);
    check("tmo_status", s, 8'h10);
    status_read(s);
    check("tmo_status_cleared", s, 8'h00);

    // short write
    send(8'h03);
    send(8'hAA);
    send(8'hBB);
    fend();
    check("short_busy", busy, 0);
    read_word(4'd3, w);
    check("short_r3_unchanged", w, 32'hA5C3_0F81);
    status_read(s);
    check("short_status", s, 8'h20);

    // illegal opcode, bytes drained until frame end
    send(8'hF0);
    check("ill_busy_drain", busy, 1);
    send(8'h01);
    send(8'h11);
    check("ill_still_drain", busy, 1);
    check("ill_no_read", out_valid, 0);
    fend();
    check("ill_idle", busy, 0);
    status_read(s);
    check("ill_status", s, 8'h40);
    send(8'h05);
    send(8'h11);
    fend();
    status_read(s);
    check("ill_rd_status", s, 8'h40);

    // frame_end wins over a byte in IDLE
    in_valid = 1'b1; in_data = 8'h10; frame_end = 1'b1;
    @(negedge clock);
    in_valid = 1'b0; frame_end = 1'b0;
    check("fe_wins_busy", busy, 0);
    check("fe_wins_valid", out_valid, 0);

    // reset mid-READ
    send(8'h13);
    check("mid_read_valid", out_valid, 1);
    reset = 1'b1;
    @(negedge clock);
    check("rst_read_valid", out_valid, 0);
    check("rst_read_busy", busy, 0);
    reset = 1'b0;
    @(negedge clock);
    for (int r = 0; r < 4; r++) begin
      read_word(r[3:0], w);
      check($sformatf("rst_r%0d", r), w, 32'h0);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/spi_fpu_sequencer.md
Name: spi_fpu_sequencer

Overview:
- Parametrised command sequencer between the SPI byte receiver/transmitter and a floating-point arithmetic unit.
- Decodes framed byte commands and holds NUM_REGS registers of WORD_BYTES bytes each.
- Runs register write/read, arithmetic issue with a timeout, and a status readback.
- The arithmetic datapath is external, connected through a start/done handshake.

Parameters:
- WORD_BYTES, 4: bytes per register. Range 2..8; transfers are LSB byte first.
- NUM_REGS, 4: number of registers. Range 2..16; RIDX = clog2(NUM_REGS).
- OP_TIMEOUT, 255: maximum cycles from op_start to op_done. Range 1..65535.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- in_valid  in  1  one-cycle strobe: a received byte is available
- in_data  in  8  received byte
- frame_end  in  1  one-cycle strobe: chip select deasserted (synchronised upstream)
- out_valid  out  1  transmit byte available
- out_ready  in  1  transmitter accepts the byte
- out_data  out  8  transmit byte
- op_start  out  1  one-cycle issue strobe
- op_code  out  2  0 = ADD, 1 = SUB, 2 = MUL
- op_a, op_b  out  8*WORD_BYTES  operands
- op_done  in  1  one-cycle result strobe
- op_result  in  8*WORD_BYTES  result, valid while op_done is high
- op_flags  in  4  compute flags, valid while op_done is high
- busy  out  1  high in every state except IDLE

Behaviour:
- Reset:
  - state = IDLE; all registers = 0.
  - out_valid, op_start, busy = 0; out_data, op_a, op_b, op_code = 0.
  - Sticky status = 0.
- Command byte: [7:4] opcode, [3:0] rd. An rd value >= NUM_REGS is illegal.
- Opcodes:
  - 0 WRITE: capture rd, go to WRITE.
  - 1 READ: snapshot reg[rd], go to READ.
  - 2/3/4 ADD/SUB/MUL: go to OPERANDS.
  - 5 STATUS: go to STATUS.
  - Any other opcode, or an illegal rd: set sticky ILLEGAL, go to DRAIN.
- OPERANDS: the next byte is {ra[3:0], rb[3:0]}. Either index >= NUM_REGS sets ILLEGAL and goes to DRAIN. Otherwise go to COMPUTE.
- COMPUTE issue:
  - op_start pulses the cycle after the operand byte.
  - op_a = reg[ra], op_b = reg[rb], op_code = opcode - 2. op_a/op_b/op_code hold until done or timeout.
- COMPUTE completion:
  - On op_done, reg[rd] <= op_result, visible the next cycle, then go to DRAIN.
  - op_done in the same cycle as op_start is legal.
- COMPUTE timeout:
  - A cycle counter starts at op_start.
  - At OP_TIMEOUT cycles without op_done: set sticky TIMEOUT, leave reg[rd] unchanged, go to DRAIN.
  - A late op_done is ignored.
- COMPUTE, other inputs:
  - in_valid sets sticky OVERRUN and the byte is dropped.
  - frame_end is recorded. Completion or timeout then goes to IDLE instead of DRAIN.
- WRITE:
  - Bytes assemble into a shadow word, byte k at bits [8k +: 8].
  - On the WORD_BYTES-th byte, reg[rd] is committed atomically, then go to DRAIN.
  - frame_end before the last byte: discard the shadow, set sticky SHORT, go to IDLE.
- READ:
  - out_valid rises the cycle after the command byte; out_data = snapshot byte k.
  - out_data is stable while out_valid && !out_ready.
  - k advances on out_valid && out_ready. After the last byte, out_valid = 0 and go to DRAIN.
  - frame_end: out_valid = 0 the next cycle, go to IDLE.
  - in_valid bytes are ignored.
- STATUS:
  - Presents one byte {busy_seen, ILLEGAL, SHORT, TIMEOUT, flags[3:0]}; busy_seen is always 0.
  - On handshake, all sticky bits clear, except any bit set in that same cycle, which remains set. Then go to DRAIN.
- DRAIN: ignores in_valid; frame_end goes to IDLE.
- frame_end in IDLE: no effect.
- frame_end and in_valid in the same cycle in IDLE: frame_end wins and the byte is dropped.
- Reset mid-operation: immediate return to reset values. Any in-flight op_done is ignored.

Optional Feature:
- Macro: SPI_FPU_SEQ_FLAGS_EN.
- Defined: op_flags is ORed into sticky flags[3:0] on op_done; flags are not captured on timeout.
- Undefined: op_flags is ignored and status bits [3:0] read 0.

Decomposition:
- Shared package spi_fpu_pkg:
  - opcode constants: OP_WRITE, OP_READ, OP_ADD, OP_SUB, OP_MUL, OP_STATUS
  - op_code encodings
  - state enum
  - status bit positions
- One sub-module: spi_fpu_regfile, NUM_REGS x WORD_BYTES. It has one full-word write port and two combinational read ports plus a third for READ snapshots.

Test Plan:
- Register round trip: frame 0x01, 0x78, 0x56, 0x34, 0x12, end, then frame 0x11, read 4 bytes → out bytes 0x78, 0x56, 0x34, 0x12. Hold out_ready low for 3 cycles at byte 2 → 0x34 holds steady.
- Add: write r0 = 0x3F800000 and r1 = 0x40000000, then frame 0x22, 0x01. Model returns 0x40400000 after 5 cycles → exactly one op_start pulse with op_a = 0x3F800000; a subsequent READ r2 returns 0x00, 0x00, 0x40, 0x40.
- Timeout: OP_TIMEOUT = 8, model never responds → TIMEOUT set after 8 cycles, r2 unchanged; STATUS byte = 0x10; a second STATUS byte read = 0x00.
- Short write: frame 0x03, 0xAA, 0xBB, end → r3 unchanged; STATUS = 0x20.
- Illegal: opcode 0xF0 → ILLEGAL set, DRAIN; further bytes ignored until frame_end; with NUM_REGS = 4, command 0x05 also sets ILLEGAL.
- Flags and reset:
  - With SPI_FPU_SEQ_FLAGS_EN, op_flags = 0x9 on op_done → STATUS = 0x09; without the macro → 0x00.
  - Reset asserted mid-READ → out_valid = 0 the next cycle; all registers read 0.
